spi_reg_slave: RTL and testbench

Parametrised SPI slave register file. It is the successor to the fixed single-mode SPI front end on the chip IO wrapper, and adds selectable CPOL/CPHA, configurable word width and register count, read-back over miso, and burst auto-increment. All SPI pins are oversampled in the system clock domain. The registers drive chip outputs directly, for example segment or control bits.

---
 rtl/spi_reg_slave.sv | 217 +++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave register file with selectable CPOL/CPHA,
// configurable word width and register count, read-back over miso and
// burst auto-increment. All SPI pins are oversampled in the clk domain,
// so f_clk must be at least 8x f_sclk.
//
// Frame format: one command byte (bit 7 = 1 for write, 0 for read; the
// address is in the low ADDR_W bits), then one or more DATA_W-bit words.
// The address increments after each word and wraps at N_REGS.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   ss           slave select, active low, asynchronous to clk
//   sclk         SPI clock, asynchronous to clk
//   mosi         serial data in, MSB first
//   miso         serial data out, MSB first
//   miso_oe      high while a frame is active
//   reg_out      register contents; reg i at [i*DATA_W +: DATA_W]
//   wr_strobe    one-clk pulse on bit i when reg i is written
//   frame_active same as miso_oe
module spi_reg_slave #(
  parameter int DATA_W = 8,
  parameter int N_REGS = 4,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ss,
  input  logic                       sclk,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [N_REGS*DATA_W-1:0]   reg_out,
  output logic [N_REGS-1:0]          wr_strobe,
  output logic                       frame_active
);

  localparam int ADDR_W = $clog2(N_REGS);
  localparam int CNT_W  = 5;
  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REGS - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Synchronisers plus one history flop per pin.
  logic ss_s1, ss_s2, ss_h;
  logic sclk_s1, sclk_s2, sclk_h;
  logic mosi_s1, mosi_s2, mosi_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_h    <= 1'b1;
      sclk_s1 <= SCLK_IDLE;
      sclk_s2 <= SCLK_IDLE;
      sclk_h  <= SCLK_IDLE;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      mosi_h  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, so this really is a shift chain of flops.
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      ss_h    <= ss_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      mosi_h  <= mosi_s2;
    end
  end

  // Edge detection on synchronised pins.
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign ss_fall     = ~ss_s2 &  ss_h;
  assign ss_rise     =  ss_s2 & ~ss_h;
  assign sclk_rise   =  sclk_s2 & ~sclk_h;
  assign sclk_fall   = ~sclk_s2 &  sclk_h;
  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [7:0]              cmd_sr;
  logic                    is_write;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       rx_sr;
  logic [DATA_W-1:0]       tx_sr;
  logic                    commit;
  logic [DATA_W-1:0]       regs [N_REGS];

  // mosi_h is the data level one clk before the sclk edge was seen, so it
  // has been stable for a while when the edge is acted on.
  logic [7:0]              cmd_next;
  logic [DATA_W-1:0]       rx_next;
  logic [ADDR_W-1:0]       addr_inc;

  assign cmd_next = {cmd_sr[6:0], mosi_h};
  assign rx_next  = {rx_sr[DATA_W-2:0], mosi_h};
  assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + 1'b1;

  // Register read mux; an address decoding past N_REGS reads as zero.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] a);
    rd_reg = '0;
    for (int i = 0; i < N_REGS; i++)
      if (a == ADDR_W'(i)) rd_reg = regs[i];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      is_write  <= 1'b0;
      addr      <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      commit    <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= '0;
      // NOTE: the register file is reset explicitly because it drives chip
      // outputs directly; it is a bank of flops, not a RAM.
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= '0;

      // A completed word is committed one clk after its last sample edge,
      // then the address advances for the next word of the burst.
      if (commit) begin
        commit <= 1'b0;
        if (is_write) begin
          for (int i = 0; i < N_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
              regs[i]      <= rx_sr;
              wr_strobe[i] <= 1'b1;
            end
          end
        end else begin
          tx_sr <= rd_reg(addr_inc);
        end
        addr <= addr_inc;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b1;
          end
        end

        CMD: begin
          if (ss_rise) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end else if (sample_edge) begin
            cmd_sr <= cmd_next;
            if (bit_cnt == CNT_W'(7)) begin
              state    <= DATA;
              bit_cnt  <= '0;
              is_write <= cmd_next[7];
              addr     <= cmd_next[ADDR_W-1:0];
              tx_sr    <= cmd_next[7] ? '0 : rd_reg(cmd_next[ADDR_W-1:0]);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          // ss rising wins over a simultaneous sample edge: the partial
          // word never sets commit, so nothing is written.
          if (ss_rise) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt <= '0;
                commit  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_edge) begin
              miso  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

  assign frame_active = miso_oe;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed bench for spi_reg_slave. Instance a is
// mode 0 with 8-bit words; instance b is mode 3 with 12-bit words. Both
// have four registers and share clk, rst and mosi. A behavioural SPI master
// drives sclk with a half period of 8 clk.
module tb_spi_reg_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mosi = 1'b0;

  logic        ss_a = 1'b1, sclk_a = 1'b0;
  logic        miso_a, oe_a, fa_a;
  logic [31:0] reg_out_a;
  logic [3:0]  wr_strobe_a;

  logic        ss_b = 1'b1, sclk_b = 1'b1;
  logic        miso_b, oe_b, fa_b;
  logic [47:0] reg_out_b;
  logic [3:0]  wr_strobe_b;

  int passed = 0;
  int total  = 0;

  logic [3:0] log_a[$];
  logic [3:0] log_b[$];

  always #5 clk = ~clk;

  spi_reg_slave #(.DATA_W(8), .N_REGS(4), .CPOL(0), .CPHA(0)) dut_a (
    .clk(clk), .rst(rst), .ss(ss_a), .sclk(sclk_a), .mosi(mosi),
    .miso(miso_a), .miso_oe(oe_a), .reg_out(reg_out_a),
    .wr_strobe(wr_strobe_a), .frame_active(fa_a)
  );

  spi_reg_slave #(.DATA_W(12), .N_REGS(4), .CPOL(1), .CPHA(1)) dut_b (
    .clk(clk), .rst(rst), .ss(ss_b), .sclk(sclk_b), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .reg_out(reg_out_b),
    .wr_strobe(wr_strobe_b), .frame_active(fa_b)
  );

  // Every clk with a nonzero strobe is logged, so a pulse longer than one
  // clk shows up as repeated entries.
  always @(negedge clk) begin
    if (wr_strobe_a != 4'b0) log_a.push_back(wr_strobe_a);
    if (wr_strobe_b != 4'b0) log_b.push_back(wr_strobe_b);
  end

  task automatic half_bit();
    repeat (8) @(negedge clk);
  endtask

  task automatic set_sclk(input int dut, input logic v);
    if (dut == 0) sclk_a = v;
    else          sclk_b = v;
  endtask

  task automatic set_ss(input int dut, input logic v);
    if (dut == 0) ss_a = v;
    else          ss_b = v;
  endtask

  // Master shifts nbits of val out MSB first and captures miso on each
  // sample edge.
  task automatic xfer(input int dut, input logic [15:0] val, input int nbits,
                      output logic [15:0] got);
    logic cpol;
    logic cpha;
    cpol = (dut != 0);
    cpha = (dut != 0);
    got = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = val[i];
        half_bit();
        got = {got[14:0], (dut == 0) ? miso_a : miso_b};
        set_sclk(dut, ~cpol);
        half_bit();
        set_sclk(dut, cpol);
      end else begin
        half_bit();
        set_sclk(dut, ~cpol);
        mosi = val[i];
        half_bit();
        got = {got[14:0], (dut == 0) ? miso_a : miso_b};
        set_sclk(dut, cpol);
      end
    end
  endtask

  task automatic frame_start(input int dut);
    set_ss(dut, 1'b0);
    half_bit();
  endtask

  task automatic frame_end(input int dut);
    half_bit();
    set_ss(dut, 1'b1);
    half_bit();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (reg_out_a !== 32'h0) $display("FAIL reset_reg_out: got %h want %h", reg_out_a, 32'h0);
    else passed++;
    total++;
    if ({miso_a, oe_a, fa_a} !== 3'b000) $display("FAIL reset_miso_oe: got %b want 000", {miso_a, oe_a, fa_a});
    else passed++;
    total++;
    if (wr_strobe_a !== 4'b0) $display("FAIL reset_strobe: got %b want 0000", wr_strobe_a);
    else passed++;
    total++;
    if ({reg_out_b, miso_b, oe_b, wr_strobe_b} !== 54'h0) $display("FAIL reset_b: got %h want 0", {reg_out_b, miso_b, oe_b, wr_strobe_b});
    else passed++;
  endtask

  task automatic test_mode0_write();
    logic [15:0] g;
    log_a.delete();
    frame_start(0);
    xfer(0, 16'h0082, 8, g);
    xfer(0, 16'h00A5, 8, g);
    frame_end(0);
    total++;
    if (reg_out_a !== 32'h00A50000) $display("FAIL m0_write_regs: got %h want %h", reg_out_a, 32'h00A50000);
    else passed++;
    total++;
    if (log_a.size() != 1) $display("FAIL m0_write_strobe_count: got %0d want 1", log_a.size());
    else if (log_a[0] !== 4'b0100) $display("FAIL m0_write_strobe: got %b want 0100", log_a[0]);
    else passed++;
    total++;
    if (oe_a !== 1'b0) $display("FAIL m0_write_oe_after: got %b want 0", oe_a);
    else passed++;
  endtask

  task automatic test_mode0_read();
    logic [15:0] g;
    log_a.delete();
    frame_start(0);
    total++;
    if ({oe_a, fa_a} !== 2'b11) $display("FAIL m0_read_oe_active: got %b want 11", {oe_a, fa_a});
    else passed++;
    xfer(0, 16'h0002, 8, g);
    xfer(0, 16'h00FF, 8, g);
    frame_end(0);
    total++;
    if (g[7:0] !== 8'hA5) $display("FAIL m0_read_data: got %h want a5", g[7:0]);
    else passed++;
    total++;
    if (reg_out_a !== 32'h00A50000) $display("FAIL m0_read_regs: got %h want %h", reg_out_a, 32'h00A50000);
    else passed++;
    total++;
    if (log_a.size() != 0) $display("FAIL m0_read_no_strobe: got %0d strobes want 0", log_a.size());
    else passed++;
    total++;
    if (miso_a !== 1'b0) $display("FAIL m0_read_miso_idle: got %b want 0", miso_a);
    else passed++;
  endtask

  task automatic test_burst_wrap();
    logic [15:0] g;
    log_a.delete();
    frame_start(0);
    xfer(0, 16'h0083, 8, g);
    xfer(0, 16'h0011, 8, g);
    xfer(0, 16'h0022, 8, g);
    frame_end(0);
    total++;
    if (reg_out_a !== 32'h11A50022) $display("FAIL burst_regs: got %h want %h", reg_out_a, 32'h11A50022);
    else passed++;
    total++;
    if (log_a.size() != 2) $display("FAIL burst_strobe_count: got %0d want 2", log_a.size());
    else if (log_a[0] !== 4'b1000 || log_a[1] !== 4'b0001)
      $display("FAIL burst_strobes: got %b,%b want 1000,0001", log_a[0], log_a[1]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] g0;
    logic [15:0] g1;
    logic [15:0] g2;
    frame_start(0);
    xfer(0, 16'h0003, 8, g0);
    xfer(0, 16'h0000, 8, g1);
    xfer(0, 16'h0000, 8, g2);
    frame_end(0);
    total++;
    if ({g1[7:0], g2[7:0]} !== 16'h1122) $display("FAIL burst_read_wrap: got %h want 1122", {g1[7:0], g2[7:0]});
    else passed++;
  endtask

  task automatic test_abort();
    logic [15:0] g;
    int n;
    bit seen;
    log_a.delete();
    frame_start(0);
    xfer(0, 16'h0081, 8, g);
    xfer(0, 16'h0016, 5, g);
    ss_a = 1'b1;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (!seen && oe_a === 1'b0) begin
        seen = 1'b1;
        n = i;
      end
    end
    total++;
    if (!seen) $display("FAIL abort_oe_timeout: miso_oe still %b after 4 clk, want 0", oe_a);
    else passed++;
    half_bit();
    total++;
    if (reg_out_a !== 32'h11A50022) $display("FAIL abort_regs: got %h want %h (oe low after %0d)", reg_out_a, 32'h11A50022, n);
    else passed++;
    total++;
    if (log_a.size() != 0 || miso_a !== 1'b0) $display("FAIL abort_strobe_miso: strobes %0d miso %b want 0 0", log_a.size(), miso_a);
    else passed++;
  endtask

  task automatic test_mode3();
    logic [15:0] g;
    log_b.delete();
    frame_start(1);
    xfer(1, 16'h0080, 8, g);
    xfer(1, 16'h0ABC, 12, g);
    frame_end(1);
    total++;
    if (reg_out_b !== 48'h000000000ABC) $display("FAIL m3_write_regs: got %h want %h", reg_out_b, 48'h000000000ABC);
    else passed++;
    total++;
    if (log_b.size() != 1 || log_b[0] !== 4'b0001) $display("FAIL m3_write_strobe: count %0d want 1 of 0001", log_b.size());
    else passed++;

    frame_start(1);
    xfer(1, 16'h0000, 8, g);
    xfer(1, 16'h0000, 12, g);
    frame_end(1);
    total++;
    if (g[11:0] !== 12'hABC) $display("FAIL m3_read_data: got %h want abc", g[11:0]);
    else passed++;

    // Reset in the middle of a read frame.
    frame_start(1);
    xfer(1, 16'h0000, 8, g);
    xfer(1, 16'h0000, 4, g);
    total++;
    if (oe_b !== 1'b1) $display("FAIL m3_mid_read_active: got %b want 1", oe_b);
    else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({reg_out_b, fa_b, oe_b, miso_b} !== 51'h0) $display("FAIL m3_rst_state: got %h want 0", {reg_out_b, fa_b, oe_b, miso_b});
    else passed++;
    ss_b = 1'b1;
    sclk_b = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if ({reg_out_b, fa_b} !== 49'h0) $display("FAIL m3_idle_after_rst: got %h want 0", {reg_out_b, fa_b});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mode0_write();
    test_mode0_read();
    test_burst_wrap();
    test_back_to_back();
    test_abort();
    test_mode3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
